// File: rtl/mdr_access_arbiter.sv
// Round-robin arbiter that sequences MDR/DRAM read and write transactions
// for two requesters (datapath and image DMA). Moore control outputs.
module mdr_access_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [1:0]        MDR_control,
    output logic [DATA_W-1:0] bus_to_MDR,
    input  logic [DATA_W-1:0] MDR_to_bus,
    output logic [ADDR_W-1:0] DRAM_addr,
    output logic              DRAM_we
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RD_WAIT   = 3'd1;
    localparam logic [2:0] RD_CAP    = 3'd2;
    localparam logic [2:0] WR_LOAD   = 3'd3;
    localparam logic [2:0] WR_COMMIT = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;

    localparam logic [1:0] MDR_HOLD     = 2'b00;
    localparam logic [1:0] MDR_LOAD_MEM = 2'b01;
    localparam logic [1:0] MDR_LOAD_BUS = 2'b10;

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    logic [2:0]        r_state;
    logic [2:0]        r_cnt;
    logic              r_owner;
    logic              r_last;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_req_any;
    logic              w_pick;
    logic              w_pick_we;
    logic [ADDR_W-1:0] w_pick_addr;
    logic [DATA_W-1:0] w_pick_wdata;

    // On a tie the requester that was not served last wins.
    assign w_req_any    = req0 | req1;
    assign w_pick       = (req0 && req1) ? ~r_last : req1;
    assign w_pick_we    = w_pick ? we1    : we0;
    assign w_pick_addr  = w_pick ? addr1  : addr0;
    assign w_pick_wdata = w_pick ? wdata1 : wdata0;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_rdata <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_any) begin
                        r_owner <= w_pick;
                        r_last  <= w_pick;
                        r_addr  <= w_pick_addr;
                        r_wdata <= w_pick_wdata;
                        if (w_pick_we) begin
                            r_state <= WR_LOAD;
                        end else begin
                            r_state <= RD_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= RD_CAP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                RD_CAP: begin
                    r_rdata <= MDR_to_bus;
                    r_state <= DONE;
                end
                WR_LOAD:   r_state <= WR_COMMIT;
                WR_COMMIT: r_state <= DONE;
                DONE:      r_state <= IDLE;
                default:   r_state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        MDR_control = MDR_HOLD;
        DRAM_we     = 1'b0;
        ack0        = 1'b0;
        ack1        = 1'b0;
        case (r_state)
            RD_WAIT:   if (r_cnt == 3'd0) MDR_control = MDR_LOAD_MEM;
            WR_LOAD:   MDR_control = MDR_LOAD_BUS;
            WR_COMMIT: DRAM_we = 1'b1;
            DONE: begin
                ack0 = ~r_owner;
                ack1 = r_owner;
            end
            default: ;
        endcase
    end

    assign busy       = (r_state != IDLE);
    assign rdata      = r_rdata;
    assign DRAM_addr  = r_addr;
    assign bus_to_MDR = r_wdata;

endmodule

// File: tb/tb_mdr_access_arbiter.sv
// Directed bench: four arbiter instances (RD_LAT 1,3,4,8), each with its own
// MDR register and DRAM model; unwritten DRAM bytes read as addr[7:0]^8'hB5.
module tb_mdr_access_arbiter;

    localparam int NI = 4;

    function automatic int lat_of(input int g);
        case (g)
            0: return 1;
            1: return 3;
            2: return 4;
            default: return 8;
        endcase
    endfunction

    logic clock;
    logic reset;

    logic        t_req0  [NI];
    logic        t_we0   [NI];
    logic [15:0] t_addr0 [NI];
    logic [7:0]  t_wd0   [NI];
    logic        t_req1  [NI];
    logic        t_we1   [NI];
    logic [15:0] t_addr1 [NI];
    logic [7:0]  t_wd1   [NI];

    logic        w_ack0  [NI];
    logic        w_ack1  [NI];
    logic [7:0]  w_rdata [NI];
    logic        w_busy  [NI];
    logic [1:0]  w_ctl   [NI];
    logic [7:0]  w_bmdr  [NI];
    logic [15:0] w_daddr [NI];
    logic        w_dwe   [NI];

    int n_vec  = 0;
    int n_miss = 0;
    int viol   = 0;
    int stray  = 0;

    logic [1:0]  h_ctl  [16];
    logic        h_we   [16];
    logic [15:0] h_addr [16];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 8;
        logic [7:0]   mem [256];
        logic [255:0] vld;
        logic [7:0]   mdr;
        logic [7:0]   dram_q;

        assign dram_q = vld[w_daddr[g][7:0]] ? mem[w_daddr[g][7:0]]
                                             : (w_daddr[g][7:0] ^ 8'hB5);

        mdr_access_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(L)) u_dut (
            .clock      (clock),
            .reset      (reset),
            .req0       (t_req0[g]),
            .we0        (t_we0[g]),
            .addr0      (t_addr0[g]),
            .wdata0     (t_wd0[g]),
            .req1       (t_req1[g]),
            .we1        (t_we1[g]),
            .addr1      (t_addr1[g]),
            .wdata1     (t_wd1[g]),
            .ack0       (w_ack0[g]),
            .ack1       (w_ack1[g]),
            .rdata      (w_rdata[g]),
            .busy       (w_busy[g]),
            .MDR_control(w_ctl[g]),
            .bus_to_MDR (w_bmdr[g]),
            .MDR_to_bus (mdr),
            .DRAM_addr  (w_daddr[g]),
            .DRAM_we    (w_dwe[g])
        );

        always @(posedge clock) begin
            if (w_ctl[g] == 2'b01)      mdr <= dram_q;
            else if (w_ctl[g] == 2'b10) mdr <= w_bmdr[g];
        end

        always @(posedge clock or posedge reset) begin
            if (reset) begin
                vld <= '0;
            end else if (w_dwe[g]) begin
                vld[w_daddr[g][7:0]] <= 1'b1;
                mem[w_daddr[g][7:0]] <= mdr;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            for (int k = 0; k < NI; k++) begin
                if (w_dwe[k] && (w_ctl[k] != 2'b00)) viol++;
                if (w_ack0[k] && w_ack1[k]) viol++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Issues one request on instance k and waits for its ack. lat counts edges
    // from the grant edge to the edge that ends the ack cycle; h_* hold the
    // outputs seen in each cycle after the grant.
    task automatic run_txn(input int k, input bit who, input logic wr,
                           input logic [15:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rd);
        int  g;
        bit  done;
        @(negedge clock);
        if (!who) begin
            t_req0[k] = 1'b1; t_we0[k] = wr; t_addr0[k] = a; t_wd0[k] = d;
        end else begin
            t_req1[k] = 1'b1; t_we1[k] = wr; t_addr1[k] = a; t_wd1[k] = d;
        end
        g    = -1;
        lat  = -1;
        rd   = 8'h00;
        done = 1'b0;
        for (int n = 0; n < 64 && !done; n++) begin
            @(posedge clock);
            #1;
            if (g < 0 && w_busy[k]) g = n;
            if (g >= 0 && (n - g) < 16) begin
                h_ctl[n-g]  = w_ctl[k];
                h_we[n-g]   = w_dwe[k];
                h_addr[n-g] = w_daddr[k];
            end
            if (who ? w_ack0[k] : w_ack1[k]) stray++;
            if (who ? w_ack1[k] : w_ack0[k]) begin
                lat  = n - g + 1;
                rd   = w_rdata[k];
                done = 1'b1;
            end
        end
        t_req0[k] = 1'b0;
        t_req1[k] = 1'b0;
    endtask

    int         lat;
    logic [7:0] rd;
    logic [7:0] held;
    int         order [4];
    logic [7:0] rlog  [4];
    int         nack;
    bit         pend0, pend1;
    int         cnt_ack;

    initial begin
        for (int k = 0; k < NI; k++) begin
            t_req0[k] = 0; t_we0[k] = 0; t_addr0[k] = '0; t_wd0[k] = '0;
            t_req1[k] = 0; t_we1[k] = 0; t_addr1[k] = '0; t_wd1[k] = '0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        check("rst_busy",  32'(w_busy[0]),  32'd0);
        check("rst_ctl",   32'(w_ctl[0]),   32'd0);
        check("rst_acks",  32'({w_ack0[0], w_ack1[0]}), 32'd0);
        check("rst_rdata", 32'(w_rdata[0]), 32'd0);
        check("rst_addr",  32'(w_daddr[0]), 32'd0);
        check("rst_bmdr",  32'(w_bmdr[0]),  32'd0);
        check("rst_dwe",   32'(w_dwe[0]),   32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Reset in the second RD_WAIT cycle of a RD_LAT=4 read.
        @(negedge clock);
        t_req0[2] = 1'b1; t_we0[2] = 1'b0; t_addr0[2] = 16'h0010;
        @(posedge clock); #1;
        check("rdrst_granted", 32'(w_busy[2]), 32'd1);
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        check("rdrst_ctl",   32'(w_ctl[2]),   32'd0);
        check("rdrst_busy",  32'(w_busy[2]),  32'd0);
        check("rdrst_addr",  32'(w_daddr[2]), 32'd0);
        check("rdrst_acks",  32'({w_ack0[2], w_ack1[2]}), 32'd0);
        t_req0[2] = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        cnt_ack = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clock); #1;
            if (w_ack0[2] || w_ack1[2] || w_busy[2]) cnt_ack++;
        end
        check("rdrst_abandoned", 32'(cnt_ack), 32'd0);
        run_txn(2, 1'b0, 1'b0, 16'h0012, 8'h00, lat, rd);
        check("rdrst_fresh_lat",  32'(lat), 32'd6);
        check("rdrst_fresh_data", 32'(rd),  32'hA7);
        check("rd4_ctl_wait",     32'({h_ctl[0], h_ctl[1], h_ctl[2], h_ctl[3]}), 32'h01);
        check("rd4_ctl_cap",      32'(h_ctl[4]), 32'd0);

        // Single read and single write, RD_LAT=1.
        run_txn(0, 1'b0, 1'b0, 16'h0010, 8'h00, lat, rd);
        check("rd1_lat",   32'(lat), 32'd3);
        check("rd1_data",  32'(rd),  32'hA5);
        check("rd1_ctl",   32'({h_ctl[0], h_ctl[1], h_ctl[2]}), 32'b01_00_00);
        run_txn(0, 1'b1, 1'b1, 16'h0020, 8'h3C, lat, rd);
        check("wr_lat",    32'(lat), 32'd3);
        check("wr_ctl",    32'({h_ctl[0], h_ctl[1]}), 32'b10_00);
        check("wr_we",     32'({h_we[0], h_we[1], h_we[2]}), 32'b010);
        check("wr_addr",   32'(h_addr[1]), 32'h0020);
        check("wr_rdheld", 32'(rd), 32'hA5);
        run_txn(0, 1'b0, 1'b0, 16'h0020, 8'h00, lat, rd);
        check("wr_readback", 32'(rd), 32'h3C);

        // Fairness on instance 1: both requesters contend from reset.
        @(negedge clock);
        t_req0[1] = 1'b1; t_we0[1] = 1'b0; t_addr0[1] = 16'h0040;
        t_req1[1] = 1'b1; t_we1[1] = 1'b1; t_addr1[1] = 16'h0041; t_wd1[1] = 8'h77;
        nack = 0; pend0 = 0; pend1 = 0;
        for (int n = 0; n < 200 && nack < 4; n++) begin
            @(posedge clock); #1;
            if (pend0) begin t_req0[1] = 1'b1; pend0 = 0; end
            if (pend1) begin t_req1[1] = 1'b1; pend1 = 0; end
            if (w_ack0[1]) begin
                order[nack] = 0; rlog[nack] = w_rdata[1]; nack++;
                t_req0[1] = 1'b0; t_addr0[1] = 16'h0041; pend0 = 1;
            end else if (w_ack1[1]) begin
                order[nack] = 1; rlog[nack] = w_rdata[1]; nack++;
                t_req1[1] = 1'b0; pend1 = 1;
            end
        end
        t_req0[1] = 1'b0;
        t_req1[1] = 1'b0;
        check("fair_count", 32'(nack), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("fair_order%0d", i), 32'(order[i]), 32'(i % 2));
        check("fair_rd0", 32'(rlog[0]), 32'hF5);
        check("fair_rd2", 32'(rlog[2]), 32'h77);
        repeat (3) @(posedge clock);

        // Latency sweep over RD_LAT = 1, 3, 8.
        for (int s = 0; s < 3; s++) begin
            int k;
            k = (s == 2) ? 3 : s;
            run_txn(k, 1'b0, 1'b0, 16'h0080 + 16'(k), 8'h00, lat, rd);
            check($sformatf("sw%0d_rd_lat", k),  32'(lat), 32'(lat_of(k) + 2));
            check($sformatf("sw%0d_rd_data", k), 32'(rd),  32'(8'h80 + 8'(k) ^ 8'hB5));
            held = rd;
            run_txn(k, 1'b1, 1'b1, 16'h0090 + 16'(k), 8'hC0 + 8'(k), lat, rd);
            check($sformatf("sw%0d_wr_lat", k),  32'(lat), 32'd3);
            check($sformatf("sw%0d_held", k),    32'(rd),  32'(held));
            run_txn(k, 1'b0, 1'b0, 16'h0090 + 16'(k), 8'h00, lat, rd);
            check($sformatf("sw%0d_rdback", k),  32'(rd),  32'(8'hC0 + 8'(k)));
        end

        repeat (2) @(posedge clock);
        check("stray_acks", 32'(stray), 32'd0);
        check("rule_viol",  32'(viol),  32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mdr_access_arbiter.md
Name: mdr_access_arbiter

Overview:
- Sequences the memory data register (MDR) and DRAM port for two requesters: requester 0 is the processor datapath, requester 1 is the image loader/downsampler DMA.
- Arbitrates round-robin, then runs each read or write transaction to completion.
- Drives the MDR 2-bit control, the bus-side MDR data, the DRAM address and the DRAM write strobe.
- Sits between the requesters and the MDR/DRAM pair.

Parameters:
- ADDR_W, 16, DRAM address width.
- DATA_W, 8, data width; matches the MDR.
- RD_LAT, 1, DRAM read latency in cycles; legal range 1..8.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 transaction request, level-sensitive.
- we0  in  1  requester 0 direction: 1 = write, 0 = read.
- addr0  in  ADDR_W  requester 0 address.
- wdata0  in  DATA_W  requester 0 write data.
- req1, we1, addr1, wdata1  in  1/1/ADDR_W/DATA_W  requester 1, same meaning as requester 0.
- ack0  out  1  one-cycle completion pulse for requester 0.
- ack1  out  1  one-cycle completion pulse for requester 1.
- rdata  out  DATA_W  read data; valid with ack, held until the next read completes.
- busy  out  1  high whenever the state is not IDLE.
- MDR_control  out  2  00 = hold, 01 = load from DRAM, 10 = load from bus.
- bus_to_MDR  out  DATA_W  write data presented to the MDR.
- MDR_to_bus  in  DATA_W  current MDR contents.
- DRAM_addr  out  ADDR_W  DRAM address.
- DRAM_we  out  1  DRAM write strobe; DRAM writes the MDR value.

Behaviour:
- Reset, asynchronous, applied immediately:
  - state = IDLE, ack0 = ack1 = 0, rdata = 0, DRAM_addr = 0, bus_to_MDR = 0.
  - MDR_control = 00, DRAM_we = 0, busy = 0.
  - Round-robin pointer last = 1, so requester 0 wins first.
  - A transaction in flight is abandoned and never acked; requesters reissue it.
- Output timing: MDR_control, DRAM_we, busy and the acks decode from the registered state (Moore). DRAM_addr, bus_to_MDR and rdata are registers.
- FSM states: IDLE, RD_WAIT, RD_CAP, WR_LOAD, WR_COMMIT, DONE.
- IDLE:
  - Outputs idle.
  - On an edge with any request pending, select the owner:
    - only one req high: that requester wins;
    - both high: the requester with index != last wins.
  - On grant, latch owner, we, addr (into DRAM_addr) and wdata (into bus_to_MDR), and set last = owner.
  - Next state: WR_LOAD if we, else RD_WAIT with cnt = RD_LAT-1.
- RD_WAIT:
  - Stays exactly RD_LAT cycles, decrementing cnt.
  - MDR_control = 01 in the final cycle (cnt == 0), so the MDR captures DRAM data on the edge leaving RD_WAIT.
  - Next state: RD_CAP.
- RD_CAP: rdata <= MDR_to_bus; MDR_control = 00; next state DONE.
- WR_LOAD: MDR_control = 10, so the MDR loads bus_to_MDR; next state WR_COMMIT.
- WR_COMMIT: DRAM_we = 1 for exactly one cycle, with DRAM_addr stable; next state DONE.
- DONE:
  - Assert ack of the owner only; return to IDLE.
  - Requests are not sampled in DONE.
- Latency, request sampled at edge E0 = ack high in the cycle following:
  - read: edge E0+RD_LAT+2;
  - write: edge E0+3.
  - The next transaction can be granted at the edge ending the IDLE cycle that follows DONE.
- Requester contract:
  - Hold req, we, addr and wdata stable until ack. The controller latches them at grant, so later changes are ignored.
  - Deassert req by the cycle after ack; a req still high in IDLE is treated as a new request.
- Other rules:
  - Only one ack is ever high in a cycle; acks never occur outside DONE.
  - DRAM_we and MDR_control != 00 are never both active.
  - DRAM_addr is only updated at grant.

Test Plan:
- Reset check: assert reset mid-cycle -> all outputs zero immediately, state IDLE, busy 0.
- Single read, RD_LAT=1: DRAM holds 8'hA5 at 0x0010; req0 read 0x0010 -> MDR_control reads 01 then 00; ack0 high one cycle at E0+3 with rdata = 8'hA5; ack1 stays 0.
- Single write: req1 write 0x0020 data 8'h3C -> MDR_control = 10 in cycle 1, DRAM_we = 1 in cycle 2 with DRAM_addr = 0x0020; DRAM[0x0020] = 8'h3C; ack1 at E0+3.
- Fairness: req0 and req1 held high together from reset, each dropped after its ack then reasserted -> grant order 0,1,0,1; no requester granted twice in a row while the other waits.
- Reset during read, RD_LAT=4: reset asserted in the second RD_WAIT cycle -> no ack, MDR_control = 00 at once; a fresh req0 read after release completes at E0+6.
- Latency sweep: RD_LAT = 1, 3, 8 -> read ack at E0+RD_LAT+2 each time; write ack always at E0+3; rdata held across an intervening write.
